shift_register: RTL and testbench
=================================

Name: shift_register

Overview:
- Parameterised serial-in, parallel-out (SIPO) shift register with a clock enable.
- Each enabled rising clock edge shifts one serial bit in at the LSB. The full register contents are presented on a parallel output.
- Used as a generic bit-collecting / delay-line building block in datapath and control logic.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, default 4: number of register stages, which is also the width of o_DATA. Legal range WIDTH >= 1.

Ports:
- i_CLK  input  1  clock; all state updates occur on the rising edge.
- i_RST  input  1  reset, synchronous and active-high; clears all stages on the rising edge while high.
- i_En  input  1  shift enable; active-high.
- i_SI  input  1  serial data in.
- o_DATA  output  WIDTH  parallel register contents, driven directly from flops with no combinational path from inputs.
- o_SO  output  1  serial out; exists only when SHIFT_REGISTER_SO_EN is defined (see Optional Feature).

Behaviour:
- Single clock domain. Reset is synchronous and active-high. No asynchronous paths.
- Internal state: WIDTH-bit register R. o_DATA = R at all times.
- Reset: at a rising edge with i_RST=1, R <= 0, regardless of i_En and i_SI.
- Reset has priority over enable. Reset asserted mid-shift discards all accumulated data.
- Shift: at a rising edge with i_RST=0 and i_En=1:
  - WIDTH >= 2: R <= {R[WIDTH-2:0], i_SI}.
  - WIDTH == 1: R <= i_SI.
  - The oldest bit R[WIDTH-1] is discarded.
- Hold: at a rising edge with i_RST=0 and i_En=0, R is unchanged; i_SI is ignored.
- Latency:
  - A bit sampled on i_SI appears at o_DATA[0] one clock after the enabled edge.
  - It reaches o_DATA[k] after k+1 enabled edges.
  - Disabled cycles do not advance the pipeline.
- After WIDTH consecutive enabled shifts, o_DATA = {first bit, ..., last bit}, MSB first.
- Continuing to shift with i_SI=1 saturates o_DATA at all-ones. No overflow indication.
- Power-up value before the first reset is unspecified. The bench must reset first.
- Inputs are sampled only at the rising edge. Mid-cycle changes to i_SI or i_En have no effect.

Optional Feature:
- Macro: SHIFT_REGISTER_SO_EN.
- Defined:
  - Adds output port o_SO (1 bit).
  - o_SO = R[WIDTH-1], the bit that the next enabled shift will discard. Driven combinationally from the flop with no logic.
  - o_SO resets to 0 with R.
  - Allows cascading instances: o_SO feeds the next instance's i_SI, with a shared i_En.
- Not defined:
  - Port o_SO is absent.
  - Behaviour of all other ports is identical.

Test Plan (WIDTH=4, 10 ns clock):
- Hold i_RST=1 for 2 edges with i_En=0 and i_SI=0 -> o_DATA=4'b0000.
- Release reset; set i_En=1 and i_SI=1 for 4 edges -> o_DATA steps through 0001, 0011, 0111, 1111.
- Set i_En=0 for 2 edges while toggling i_SI -> o_DATA holds 1111.
- Set i_En=1 and drive i_SI=1,0,1,0 on successive edges -> o_DATA steps through 1111, 1110, 1101, 1010.
- Set i_En=0 and drive i_SI=1,1,0,0,0 -> o_DATA stays 1010 throughout.
- Assert i_RST=1 with i_En=1 and i_SI=1,0,0,0 for 4 edges -> o_DATA=0000 every cycle (reset beats enable). Then release with i_En=0 and i_SI=1 -> o_DATA stays 0000.
- With SHIFT_REGISTER_SO_EN defined: after shifting in 1,0,0,0 -> o_SO=1. After one more enabled shift with i_SI=0 -> o_SO=0.

Source files
------------

// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register with clock enable; SHIFT_REGISTER_SO_EN adds serial-out o_SO.
// Latency: a bit sampled on i_SI reaches o_DATA[k] after k+1 enabled edges; disabled edges hold state.
// Backpressure: none; i_En is the only advance control and every enabled edge shifts.
module shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_En,
    input  logic             i_SI,
    output logic [WIDTH-1:0] o_DATA
`ifdef SHIFT_REGISTER_SO_EN
    ,
    output logic             o_SO
`endif
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shift_val;

    // A one-stage register has no lower slice to carry, so it simply reloads from i_SI.
    generate
        if (WIDTH == 1) begin : g_single
            assign shift_val = i_SI;
        end else begin : g_multi
            assign shift_val = {data_q[WIDTH-2:0], i_SI};
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (i_En) begin
            data_d = shift_val;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_DATA = data_q;

`ifdef SHIFT_REGISTER_SO_EN
    assign o_SO = data_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_shift_register.sv
// Directed self-checking bench for shift_register at WIDTH=4 with a 10 ns clock.
module tb_shift_register;

    logic       clk;
    logic       i_RST;
    logic       i_En;
    logic       i_SI;
    logic [3:0] o_DATA;
`ifdef SHIFT_REGISTER_SO_EN
    logic       o_SO;
`endif

    int checks;
    int errors;

    shift_register #(.WIDTH(4)) dut (
        .i_CLK  (clk),
        .i_RST  (i_RST),
        .i_En   (i_En),
        .i_SI   (i_SI),
        .o_DATA (o_DATA)
`ifdef SHIFT_REGISTER_SO_EN
        ,
        .o_SO   (o_SO)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        i_RST = 1'b1; i_En = 1'b0; i_SI = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== 4'b0000) begin
                errors++;
                $display("FAIL reset[%0d]: o_DATA=%b expected=%b", i, o_DATA, 4'b0000);
            end
        end
    endtask

    task automatic test_shift_ones;
        logic [3:0] exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            i_RST = 1'b0; i_En = 1'b1; i_SI = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== exp[i]) begin
                errors++;
                $display("FAIL shift_ones[%0d]: o_DATA=%b expected=%b", i, o_DATA, exp[i]);
            end
        end
    endtask

    task automatic test_hold_toggle;
        for (int i = 0; i < 2; i++) begin
            i_En = 1'b0; i_SI = i[0];
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== 4'b1111) begin
                errors++;
                $display("FAIL hold_toggle[%0d]: o_DATA=%b expected=%b", i, o_DATA, 4'b1111);
            end
        end
    endtask

    task automatic test_pattern;
        logic       si  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp [4] = '{4'b1111, 4'b1110, 4'b1101, 4'b1010};
        for (int i = 0; i < 4; i++) begin
            i_En = 1'b1; i_SI = si[i];
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== exp[i]) begin
                errors++;
                $display("FAIL pattern[%0d]: o_DATA=%b expected=%b", i, o_DATA, exp[i]);
            end
        end
    endtask

    task automatic test_hold_pattern;
        logic si [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            i_En = 1'b0; i_SI = si[i];
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== 4'b1010) begin
                errors++;
                $display("FAIL hold_pattern[%0d]: o_DATA=%b expected=%b", i, o_DATA, 4'b1010);
            end
        end
    endtask

    task automatic test_reset_priority;
        logic si [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            i_RST = 1'b1; i_En = 1'b1; i_SI = si[i];
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== 4'b0000) begin
                errors++;
                $display("FAIL reset_priority[%0d]: o_DATA=%b expected=%b", i, o_DATA, 4'b0000);
            end
        end
        for (int i = 0; i < 2; i++) begin
            i_RST = 1'b0; i_En = 1'b0; i_SI = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release[%0d]: o_DATA=%b expected=%b", i, o_DATA, 4'b0000);
            end
        end
    endtask

    // A lone 1 walks up the register, pauses on a disabled edge, then falls off the MSB.
    task automatic test_walk_and_stall;
        logic       en  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       si  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b1000, 4'b0000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            i_RST = 1'b0; i_En = en[i]; i_SI = si[i];
            @(posedge clk); #1;
            checks++;
            if (o_DATA !== exp[i]) begin
                errors++;
                $display("FAIL walk_and_stall[%0d]: o_DATA=%b expected=%b", i, o_DATA, exp[i]);
            end
        end
    endtask

`ifdef SHIFT_REGISTER_SO_EN
    task automatic test_serial_out;
        logic si  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic exp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        i_RST = 1'b1; i_En = 1'b0; i_SI = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_SO !== 1'b0) begin
            errors++;
            $display("FAIL so_reset: o_SO=%b expected=%b", o_SO, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            i_RST = 1'b0; i_En = 1'b1; i_SI = si[i];
            @(posedge clk); #1;
            checks++;
            if (o_SO !== exp[i]) begin
                errors++;
                $display("FAIL serial_out[%0d]: o_SO=%b expected=%b", i, o_SO, exp[i]);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        i_RST  = 1'b1;
        i_En   = 1'b0;
        i_SI   = 1'b0;
        test_reset();
        test_shift_ones();
        test_hold_toggle();
        test_pattern();
        test_hold_pattern();
        test_reset_priority();
        test_walk_and_stall();
`ifdef SHIFT_REGISTER_SO_EN
        test_serial_out();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
